// File: rtl/oled_i2c_target_pkg.sv
// Shared constants for the OLED I2C write-side target: FSM encoding, default
// bus address and the two control-byte values used by the OLED master.
package oled_i2c_target_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_REG      = 3'd3,
      ST_REG_ACK  = 3'd4,
      ST_DATA     = 3'd5,
      ST_DATA_ACK = 3'd6,
      ST_IGNORE   = 3'd7
   } state_t;

   localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h3C;
   localparam logic [7:0] CTRL_CMD            = 8'h00;
   localparam logic [7:0] CTRL_DATA           = 8'h40;

   function automatic logic isAddrHit(input logic [7:0] addrByte, input logic [6:0] target);
      return addrByte[7:1] == target;
   endfunction

endpackage

// File: rtl/oled_i2c_target_if.sv
// Bus-side and write-port signals of the OLED I2C target, grouped so the
// bench (master modport) and the target (slave modport) share one bundle.
interface oled_i2c_target_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_out;
   logic       sda_oen;
   logic       wr_en;
   logic [7:0] wr_reg_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       nack_read;

   modport slave (
      input  scl_in, sda_in,
      output sda_out, sda_oen, wr_en, wr_reg_addr, wr_data, busy, nack_read
   );

   modport master (
      output scl_in, sda_in,
      input  sda_out, sda_oen, wr_en, wr_reg_addr, wr_data, busy, nack_read
   );
endinterface

// File: rtl/oled_i2c_target_line_filter.sv
// Pad synchroniser plus glitch filter for one I2C line; emits the accepted
// level and single-cycle rise/fall pulses aligned with the level change.
module oled_i2c_target_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int GLITCH_LEN  = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pad_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = $clog2(GLITCH_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, fall_q;
   logic                   syncOut;

   assign syncOut = sync_q[SYNC_STAGES-1];

   // A new level is accepted only after GLITCH_LEN consecutive disagreeing samples.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (syncOut != level_q) begin
         if (cnt_q == CW'(GLITCH_LEN - 1)) begin
            level_d = syncOut;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= '1;
         cnt_q   <= '0;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= level_d & ~level_q;
         fall_q  <= ~level_d & level_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/oled_i2c_target.sv
// Write-only I2C target modelling the OLED controller: address, one register
// byte, then any number of data bytes delivered as one-cycle write strobes.
module oled_i2c_target
   import oled_i2c_target_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
   parameter int         SYNC_STAGES = 2,
   parameter int         GLITCH_LEN  = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   oled_i2c_target_if.slave  bus
);

   logic       sclLevel, sclRise, sclFall;
   logic       sdaLevel, sdaRise, sdaFall;
   logic       startDet, stopDet;
   logic [7:0] byteNext_d;

   state_t     state_q;
   logic [2:0] bitCnt_q;
   logic [7:0] shift_q;
   logic       sdaOen_q, wrEn_q, busy_q, nackRead_q;
   logic [7:0] wrRegAddr_q, wrData_q;

   oled_i2c_target_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_LEN(GLITCH_LEN)) u_sclFilter (
      .clk_i(clk_i), .rst_ni(rst_ni), .pad_i(bus.scl_in),
      .level_o(sclLevel), .rise_o(sclRise), .fall_o(sclFall)
   );

   oled_i2c_target_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_LEN(GLITCH_LEN)) u_sdaFilter (
      .clk_i(clk_i), .rst_ni(rst_ni), .pad_i(bus.sda_in),
      .level_o(sdaLevel), .rise_o(sdaRise), .fall_o(sdaFall)
   );

   assign startDet   = sdaFall & sclLevel;
   assign stopDet    = sdaRise & sclLevel;
   assign byteNext_d = {shift_q[6:0], sdaLevel};

   // STOP and START outrank bit sampling; the 3-bit counter wraps to 0 when a byte completes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         bitCnt_q    <= '0;
         shift_q     <= '0;
         sdaOen_q    <= 1'b1;
         wrEn_q      <= 1'b0;
         busy_q      <= 1'b0;
         nackRead_q  <= 1'b0;
         wrRegAddr_q <= '0;
         wrData_q    <= '0;
      end else begin
         wrEn_q     <= 1'b0;
         nackRead_q <= 1'b0;
         if (stopDet) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            sdaOen_q <= 1'b1;
            bitCnt_q <= '0;
         end else if (startDet) begin
            state_q  <= ST_ADDR;
            sdaOen_q <= 1'b1;
            bitCnt_q <= '0;
         end else begin
            case (state_q)
               ST_ADDR, ST_REG, ST_DATA: begin
                  if (sclRise) begin
                     shift_q  <= byteNext_d;
                     bitCnt_q <= bitCnt_q + 3'd1;
                     if (bitCnt_q == 3'd7) begin
                        if (state_q == ST_ADDR) begin
                           if (!isAddrHit(byteNext_d, TARGET_ADDR)) begin
                              state_q <= ST_IGNORE;
                              busy_q  <= 1'b0;
                           end else if (byteNext_d[0]) begin
                              state_q    <= ST_IGNORE;
                              busy_q     <= 1'b0;
                              nackRead_q <= 1'b1;
                           end else begin
                              state_q <= ST_ADDR_ACK;
                              busy_q  <= 1'b1;
                           end
                        end else if (state_q == ST_REG) begin
                           wrRegAddr_q <= byteNext_d;
                           state_q     <= ST_REG_ACK;
                        end else begin
                           wrData_q <= byteNext_d;
                           wrEn_q   <= 1'b1;
                           state_q  <= ST_DATA_ACK;
                        end
                     end
                  end
               end
               // First SCL fall pulls SDA for the ACK clock, the second releases it.
               ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
                  if (sclFall) begin
                     sdaOen_q <= ~sdaOen_q;
                     if (!sdaOen_q) begin
                        state_q <= (state_q == ST_ADDR_ACK) ? ST_REG : ST_DATA;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign bus.sda_out     = 1'b0;
   assign bus.sda_oen     = sdaOen_q;
   assign bus.wr_en       = wrEn_q;
   assign bus.wr_reg_addr = wrRegAddr_q;
   assign bus.wr_data     = wrData_q;
   assign bus.busy        = busy_q;
   assign bus.nack_read   = nackRead_q;

endmodule

// File: tb/tb_oled_i2c_target.sv
// Bench for oled_i2c_target: bit-banged I2C master on an open-drain SDA model,
// directed scenarios plus randomised write transactions against a write scoreboard.
module tb_oled_i2c_target;
   import oled_i2c_target_pkg::*;

   localparam int         Q    = 10;
   localparam logic [6:0] ADDR = DEFAULT_TARGET_ADDR;

   logic        clk;
   logic        rstN;
   logic        masterScl;
   logic        masterSda;
   logic        sdaLine;
   int          checkCount   = 0;
   int          failCount    = 0;
   int          nackCount    = 0;
   int          oenLowCycles = 0;
   logic [15:0] obsQ[$];
   logic [15:0] expQ[$];
   logic [7:0]  txData[$];
   logic [7:0]  glitchMask   = 8'h00;

   oled_i2c_target_if busIf();

   oled_i2c_target dut (
      .clk_i  (clk),
      .rst_ni (rstN),
      .bus    (busIf)
   );

   assign sdaLine      = masterSda & (busIf.sda_oen | busIf.sda_out);
   assign busIf.scl_in = masterScl;
   assign busIf.sda_in = sdaLine;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Observes the write port, read NACKs and SDA drive once per cycle, away from the active edge.
   always @(negedge clk) begin
      if (busIf.wr_en === 1'b1) obsQ.push_back({busIf.wr_reg_addr, busIf.wr_data});
      if (busIf.nack_read === 1'b1) nackCount++;
      if (busIf.sda_oen === 1'b0) oenLowCycles++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic sendStart();
      waitClk(Q);
      masterSda = 1'b1;
      waitClk(Q);
      masterScl = 1'b1;
      waitClk(Q);
      masterSda = 1'b0;
      waitClk(Q);
      masterScl = 1'b0;
      waitClk(Q);
   endtask

   task automatic sendStop();
      waitClk(Q);
      masterSda = 1'b0;
      waitClk(Q);
      masterScl = 1'b1;
      waitClk(Q);
      masterSda = 1'b1;
      waitClk(Q);
   endtask

   task automatic sendBit(input logic b, input logic glitch);
      waitClk(Q);
      masterSda = b;
      waitClk(Q);
      masterScl = 1'b1;
      waitClk(8);
      if (glitch) begin
         masterSda = ~b;
         waitClk(2);
         masterSda = b;
      end else begin
         waitClk(2);
      end
      waitClk(Q);
      masterScl = 1'b0;
   endtask

   // Returns the SDA line level seen in the middle of the ACK clock: 0 means ACK.
   task automatic sendByte(input logic [7:0] b, input logic [7:0] gMask, output logic ack);
      for (int i = 7; i >= 0; i--) sendBit(b[i], gMask[i]);
      waitClk(Q);
      masterSda = 1'b1;
      waitClk(Q);
      masterScl = 1'b1;
      waitClk(Q);
      ack = sdaLine;
      waitClk(Q);
      masterScl = 1'b0;
   endtask

   task automatic compareStrobes();
      checkOutput("strobe_count", 32'(obsQ.size()), 32'(expQ.size()));
      while (obsQ.size() > 0 && expQ.size() > 0)
         checkOutput("strobe_reg_data", 32'(obsQ.pop_front()), 32'(expQ.pop_front()));
      obsQ.delete();
      expQ.delete();
   endtask

   // One full transaction with STOP; the model decides from the address byte alone what the target must do.
   task automatic applyStimulus(input logic [7:0] addrByte, input logic [7:0] regByte, input int nData);
      logic ack;
      logic matchW;
      logic matchR;
      int   nackBefore;
      int   lowBefore;
      matchW     = (addrByte[7:1] == ADDR) && (addrByte[0] == 1'b0);
      matchR     = (addrByte[7:1] == ADDR) && (addrByte[0] == 1'b1);
      nackBefore = nackCount;
      lowBefore  = oenLowCycles;
      sendStart();
      sendByte(addrByte, 8'h00, ack);
      checkOutput("addr_ack", 32'(ack), 32'(!matchW));
      checkOutput("busy_after_addr", 32'(busIf.busy), 32'(matchW));
      if (matchW) begin
         sendByte(regByte, 8'h00, ack);
         checkOutput("reg_ack", 32'(ack), 32'd0);
         for (int i = 0; i < nData; i++) begin
            sendByte(txData[i], (i == 0) ? glitchMask : 8'h00, ack);
            checkOutput("data_ack", 32'(ack), 32'd0);
            expQ.push_back({regByte, txData[i]});
         end
      end
      sendStop();
      waitClk(12);
      checkOutput("busy_after_stop", 32'(busIf.busy), 32'd0);
      checkOutput("nack_read_pulses", 32'(nackCount - nackBefore), 32'(matchR));
      if (!matchW) checkOutput("sda_never_low", 32'(oenLowCycles - lowBefore), 32'd0);
      compareStrobes();
      waitClk(10);
   endtask

   initial begin
      logic       ack;
      logic [6:0] rAddr;
      logic [7:0] rReg;
      int         sel;
      int         nData;

      rstN      = 1'b0;
      masterScl = 1'b1;
      masterSda = 1'b1;
      waitClk(4);
      checkOutput("rst_sda_oen", 32'(busIf.sda_oen), 32'd1);
      checkOutput("rst_wr_en", 32'(busIf.wr_en), 32'd0);
      checkOutput("rst_busy", 32'(busIf.busy), 32'd0);
      checkOutput("rst_nack_read", 32'(busIf.nack_read), 32'd0);
      checkOutput("rst_wr_reg_addr", 32'(busIf.wr_reg_addr), 32'd0);
      checkOutput("rst_wr_data", 32'(busIf.wr_data), 32'd0);
      rstN = 1'b1;
      waitClk(10);

      $display("[TB] command write");
      txData = '{8'hAE};
      applyStimulus({ADDR, 1'b0}, CTRL_CMD, 1);

      $display("[TB] multi-byte data write");
      txData = '{8'hFF, 8'h00, 8'h55};
      applyStimulus({ADDR, 1'b0}, CTRL_DATA, 3);

      $display("[TB] foreign address and read request");
      applyStimulus({7'h3D, 1'b0}, CTRL_CMD, 0);
      applyStimulus({ADDR, 1'b1}, CTRL_CMD, 0);

      $display("[TB] partial byte then repeated start");
      sendStart();
      sendByte({ADDR, 1'b0}, 8'h00, ack);
      checkOutput("rs_addr_ack", 32'(ack), 32'd0);
      sendByte(CTRL_CMD, 8'h00, ack);
      checkOutput("rs_reg_ack", 32'(ack), 32'd0);
      sendBit(1'b1, 1'b0);
      sendBit(1'b0, 1'b0);
      sendBit(1'b1, 1'b0);
      sendBit(1'b1, 1'b0);
      sendStart();
      checkOutput("rs_busy_held", 32'(busIf.busy), 32'd1);
      txData = '{8'h12};
      applyStimulus({ADDR, 1'b0}, CTRL_DATA, 1);

      $display("[TB] asynchronous reset inside an ACK slot");
      sendStart();
      for (int i = 7; i >= 0; i--) sendBit(ADDR[(i > 0) ? i - 1 : 0] & (i > 0), 1'b0);
      waitClk(Q);
      masterSda = 1'b1;
      waitClk(Q);
      masterScl = 1'b1;
      waitClk(4);
      checkOutput("ack_driven_before_reset", 32'(busIf.sda_oen), 32'd0);
      checkOutput("busy_before_reset", 32'(busIf.busy), 32'd1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async_reset_sda_oen", 32'(busIf.sda_oen), 32'd1);
      checkOutput("async_reset_busy", 32'(busIf.busy), 32'd0);
      waitClk(3);
      rstN = 1'b1;
      waitClk(10);
      obsQ.delete();
      txData = '{8'h3A, 8'hC5};
      applyStimulus({ADDR, 1'b0}, CTRL_DATA, 2);

      $display("[TB] SDA glitches while SCL is high");
      glitchMask = 8'b1100_0000;
      txData = '{8'hA5};
      applyStimulus({ADDR, 1'b0}, CTRL_DATA, 1);
      glitchMask = 8'h00;

      $display("[TB] randomised transactions");
      for (int t = 0; t < 8; t++) begin
         sel = int'($urandom_range(0, 5));
         rAddr = ADDR;
         if (sel == 0) begin
            rAddr = 7'($urandom_range(0, 127));
            if (rAddr == ADDR) rAddr = ADDR + 7'd1;
         end
         sel = int'($urandom_range(0, 2));
         rReg = (sel == 0) ? CTRL_CMD : ((sel == 1) ? CTRL_DATA : 8'($urandom));
         nData = int'($urandom_range(0, 3));
         txData.delete();
         for (int i = 0; i < nData; i++) txData.push_back(8'($urandom));
         applyStimulus({rAddr, (sel == 2) && ($urandom_range(0, 1) == 1)}, rReg, nData);
      end

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
